// File: rtl/wr_mem.sv
// Write-side DDR engine: drains one packed video line from a FWFT FIFO
// into the MCB write port as fixed-length bursts, double-buffered by frame.
module wr_mem #(
  parameter int DWIDTH      = 128,
  parameter int BRST_LENGTH = 45,
  parameter int BRSTNUM     = 4,
  parameter int DEPTH       = 900
) (
  input  logic                memclk,
  input  logic                rst,
  input  logic                vs_sync,
  input  logic [DWIDTH-1:0]   src_data,
  input  logic                src_empty,
  input  logic [8:0]          src_count,
  output logic                src_rd_en,
  input  logic                memcon_en,
  output logic                memcon_donep,
  input  logic [1:0]          arb_state,
  output logic                mcb_wr_en,
  output logic [DWIDTH-1:0]   mcb_wr_data,
  output logic [DWIDTH/8-1:0] mcb_wr_mask,
  input  logic                mcb_wr_full,
  input  logic [6:0]          mcb_wr_count,
  output logic                mcb_cmd_en,
  output logic [2:0]          mcb_cmd_instr,
  output logic [5:0]          mcb_cmd_bl,
  output logic [29:0]         mcb_cmd_byte_addr,
  input  logic                mcb_cmd_full,
  output logic                wr_frame,
  output logic                ovf
);

  localparam int BCW = (BRSTNUM > 1) ? $clog2(BRSTNUM) : 1;

  localparam logic [12:0]    COL_STEP  = 13'(BRST_LENGTH * DWIDTH / 8);
  localparam logic [5:0]     BL        = 6'(BRST_LENGTH - 1);
  localparam logic [8:0]     SRC_MIN   = 9'(BRST_LENGTH);
  localparam logic [6:0]     MCB_MAX   = 7'(64 - BRST_LENGTH);
  localparam logic [10:0]    LAST_LINE = 11'(DEPTH - 1);
  localparam logic [BCW-1:0] LAST_BRST = BCW'(BRSTNUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DATA,
    S_CMD,
    S_NEXT
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     cntr_q, cntr_d;
  logic [BCW-1:0] brst_q, brst_d;
  logic [12:0]    col_q, col_d;
  logic [10:0]    line_q, line_d;
  logic           frame_q, frame_d;
  logic           ovf_q, ovf_d;
  logic           vs_pend_q, vs_pend_d;
  logic           done_q, done_d;
  logic [3:0]     dsh_q, dsh_d;
  logic [29:0]    addr_q, addr_d;
  logic           push;

  always_ff @(posedge memclk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cntr_q    <= '0;
      brst_q    <= '0;
      col_q     <= '0;
      line_q    <= '0;
      frame_q   <= 1'b0;
      ovf_q     <= 1'b0;
      vs_pend_q <= 1'b0;
      done_q    <= 1'b0;
      dsh_q     <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cntr_q    <= cntr_d;
      brst_q    <= brst_d;
      col_q     <= col_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      ovf_q     <= ovf_d;
      vs_pend_q <= vs_pend_d;
      done_q    <= done_d;
      dsh_q     <= dsh_d;
      addr_q    <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cntr_d    = cntr_q;
    brst_d    = brst_q;
    col_d     = col_q;
    line_d    = line_q;
    frame_d   = frame_q;
    ovf_d     = ovf_q;
    vs_pend_d = vs_pend_q | vs_sync;
    done_d    = done_q;
    dsh_d     = {dsh_q[2:0], done_q};
    addr_d    = addr_q;

    push       = (state_q == S_DATA) && !src_empty && !mcb_wr_full;
    mcb_cmd_en = (state_q == S_CMD) && !mcb_cmd_full
                 && (arb_state == 2'b01);

    // A frame start while a line is in flight is deferred to IDLE
    if (vs_sync && (state_q != S_IDLE)) ovf_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (vs_sync || vs_pend_q) begin
          line_d    = '0;
          col_d     = '0;
          brst_d    = '0;
          frame_d   = ~frame_q;
          vs_pend_d = 1'b0;
        end
        if (memcon_en && !memcon_donep) state_d = S_FILL;
      end
      S_FILL: begin
        if ((src_count >= SRC_MIN) && (mcb_wr_count <= MCB_MAX)) begin
          cntr_d  = '0;
          addr_d  = {5'd0, frame_q, line_q, col_q};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (push) begin
          cntr_d = cntr_q + 6'd1;
          if (cntr_q == BL) state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (mcb_cmd_en) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (brst_q == LAST_BRST) begin
          brst_d  = '0;
          col_d   = '0;
          line_d  = (line_q == LAST_LINE) ? 11'd0 : line_q + 11'd1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          brst_d  = brst_q + BCW'(1);
          col_d   = col_q + COL_STEP;
          state_d = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign src_rd_en         = push;
  assign mcb_wr_en         = push;
  assign mcb_wr_data       = src_data;
  assign mcb_wr_mask       = '0;
  assign mcb_cmd_instr     = 3'b000;
  assign mcb_cmd_bl        = BL;
  assign mcb_cmd_byte_addr = addr_q;
  assign memcon_donep      = done_q | (dsh_q != 4'd0);
  assign wr_frame          = frame_q;
  assign ovf               = ovf_q;

endmodule
